// File: rtl/pig_disp_pkg.sv
// rtl/pig_disp_pkg.sv - shared display constants and types for the seven-segment driver.
// All segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package pig_disp_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to active-low segment decoder.
// Non-BCD codes render as a dash; blank overrides the digit entirely.
module seg7_decode
  import pig_disp_pkg::*;
(
  input  bcd_digit_t  digit,
  input  logic        blank,
  output logic [6:0]  seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - eight-digit multiplexed common-anode seven-segment scanner.
// Define SEG7_LZB_EN to compile in leading-zero blanking (digit 0 is never blanked).
module seg7_scan
  import pig_disp_pkg::*;
#(
  parameter int DIV    = 50000,
  parameter int DIGITS = 8
) (
  input  logic        clock,
  input  logic        a_rst_n,
  input  logic [31:0] bcd,
  input  logic        bcd_valid,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        tick
);

  localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
  localparam logic [2:0]     IDX_LAST   = 3'(DIGITS - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [2:0]    nidx;
  logic [31:0]   shadow;
  logic          wrap;
  logic          blank;
  bcd_digit_t    digit;
  logic [6:0]    seg_next;

  assign wrap  = (presc == PRESC_LAST);
  assign nidx  = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
  assign digit = shadow[{nidx, 2'b00} +: 4];
  assign dp    = 1'b1;

`ifdef SEG7_LZB_EN
  // Walk from the MSD down; blank the selected digit while everything above it is zero.
  always_comb begin
    logic zeros_above;
    zeros_above = 1'b1;
    blank       = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      if (shadow[4*k +: 4] != 4'd0) zeros_above = 1'b0;
      if (3'(k) == nidx) blank = zeros_above;
    end
  end
`else
  assign blank = 1'b0;
`endif

  seg7_decode u_decode (
    .digit (digit),
    .blank (blank),
    .seg   (seg_next)
  );

  always_ff @(posedge clock or negedge a_rst_n) begin
    if (!a_rst_n) begin
      shadow <= 32'd0;
    end else if (bcd_valid) begin
      shadow <= bcd;
    end
  end

  // Outputs latch on the wrap edge from the pre-capture shadow, so a coincident strobe shows next tick.
  always_ff @(posedge clock or negedge a_rst_n) begin
    if (!a_rst_n) begin
      presc <= '0;
      idx   <= IDX_LAST;
      tick  <= 1'b0;
      an    <= 8'hFF;
      seg   <= SEG_BLANK;
    end else begin
      tick <= wrap;
      if (wrap) begin
        presc <= '0;
        idx   <= nidx;
        an    <= ~(8'b1 << nidx);
        seg   <= seg_next;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - scoreboard bench for seg7_scan with DIV=4.
// Expected digit frames are queued at capture time and checked on each tick.
module tb_seg7_scan;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        a_rst_n = 1'b0;
  logic [31:0] bcd = 32'd0;
  logic        bcd_valid = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        tick;

  int vectors = 0;
  int miscompares = 0;
  int cur = 7;
  logic [31:0] sh = 32'd0;
  logic [14:0] sb_q[$];

  seg7_scan #(.DIV(DIV), .DIGITS(8)) dut (
    .clock     (clock),
    .a_rst_n   (a_rst_n),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .tick      (tick)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [14:0] frame(input logic [31:0] v, input int d);
    logic [7:0] a;
    logic [6:0] s;
    a = 8'hFF;
    a[d] = 1'b0;
    s = seg_of(4'((v >> (4 * d)) & 32'hF));
`ifdef SEG7_LZB_EN
    if (d != 0 && (v >> (4 * d)) == 32'd0) s = 7'h7F;
`endif
    return {a, s};
  endfunction

  task automatic push_frames(input logic [31:0] v, input int first, input int n);
    for (int j = 0; j < n; j++) sb_q.push_back(frame(v, (first + j) % 8));
  endtask

  always @(negedge clock) begin
    if (a_rst_n && tick && sb_q.size() > 0) begin
      logic [14:0] e;
      e = sb_q.pop_front();
      vectors++;
      if ({an, seg} !== e) begin
        miscompares++;
        $display("FAIL scoreboard_tick an=%h seg=%b expected an=%h seg=%b", an, seg, e[14:7], e[6:0]);
      end
    end
  end

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!tick && n < 2 * DIV + 2);
    vectors++;
    if (!tick) begin
      miscompares++;
      $display("FAIL tick_timeout waited=%0d cycles required tick within %0d", n, 2 * DIV + 2);
    end else begin
      cur = (cur + 1) % 8;
    end
  endtask

  task automatic capture(input logic [31:0] v);
    bcd = v;
    bcd_valid = 1'b1;
    @(posedge clock);
    #1;
    bcd_valid = 1'b0;
    sh = v;
  endtask

  task automatic test_reset();
    int n;
    a_rst_n = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({an, seg, dp, tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state an=%h seg=%h dp=%b tick=%b expected FF 7F 1 0", an, seg, dp, tick);
    end
    sh = 32'd0;
    cur = 7;
    push_frames(sh, 0, 1);
    a_rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (n == DIV - 1) begin
        vectors++;
        if (an !== 8'hFF) begin
          miscompares++;
          $display("FAIL dark_before_tick an=%h expected FF", an);
        end
      end
    end while (!tick && n < 3 * DIV);
    vectors++;
    if (!tick || n != DIV) begin
      miscompares++;
      $display("FAIL first_tick_latency got=%0d expected=%0d", n, DIV);
    end
    cur = 0;
  endtask

  task automatic test_scan();
    wait_tick();
    capture(32'h12345678);
    vectors++;
    if (tick !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_width tick=%b expected 0", tick);
    end
    push_frames(sh, cur + 1, 9);
    repeat (9) wait_tick();
  endtask

  task automatic test_nonbcd();
    wait_tick();
    capture(32'h0000000A);
    push_frames(sh, cur + 1, 8);
    repeat (8) wait_tick();
  endtask

  task automatic test_lzb();
    wait_tick();
    capture(32'h00002649);
    push_frames(sh, cur + 1, 8);
    repeat (8) wait_tick();
    vectors++;
    if (dp !== 1'b1) begin
      miscompares++;
      $display("FAIL dp_off dp=%b expected 1", dp);
    end
  endtask

  task automatic test_collision();
    wait_tick();
    repeat (DIV - 1) @(posedge clock);
    #1;
    push_frames(sh, cur + 1, 1);
    push_frames(32'h99999999, cur + 2, 1);
    capture(32'h99999999);
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_align tick=%b expected 1", tick);
    end
    cur = (cur + 1) % 8;
    wait_tick();
  endtask

  task automatic test_back_to_back();
    wait_tick();
    bcd = 32'h11111111;
    bcd_valid = 1'b1;
    @(posedge clock);
    #1;
    bcd = 32'h87654321;
    @(posedge clock);
    #1;
    bcd_valid = 1'b0;
    sh = 32'h87654321;
    push_frames(sh, cur + 1, 8);
    repeat (8) wait_tick();
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (2) @(posedge clock);
    #1;
    a_rst_n = 1'b0;
    #1;
    vectors++;
    if ({an, seg, tick} !== {8'hFF, 7'h7F, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_async an=%h seg=%h tick=%b expected FF 7F 0", an, seg, tick);
    end
    sh = 32'd0;
    cur = 7;
    push_frames(sh, 0, 2);
    a_rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!tick && n < 3 * DIV);
    vectors++;
    if (!tick || n != DIV) begin
      miscompares++;
      $display("FAIL reset_mid_restart got=%0d expected=%0d", n, DIV);
    end
    cur = 0;
    wait_tick();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_nonbcd();
    test_lzb();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clock);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
